// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: owner encoding, default bus widths
// and the fixed-priority winner selection used by dmem_arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam int WAIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    // Owner of the access issued last cycle; rd marks that read data is due now.
    typedef struct packed {
        owner_e owner;
        logic   rd;
    } owner_state_t;

    function automatic owner_e pick_winner(input logic cpu_req,
                                           input logic dbg_req,
                                           input logic force_dbg);
        if (force_dbg && dbg_req)
            return OWN_DBG;
        else if (cpu_req)
            return OWN_CPU;
        else if (dbg_req)
            return OWN_DBG;
        else
            return OWN_NONE;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/debug requesters, the arbiter and the data RAM.
// slave = arbiter side, master = requesters plus RAM (the surrounding wrapper).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_wEn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dataIn;
    logic [DATA_W-1:0] ram_dataOut;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut
    );

endinterface

// File: rtl/dmem_arb_age_counter.sv
// Debug-port starvation counter: counts consecutive denied debug cycles and
// raises force_dbg once the count reaches MAX_WAIT (legal range 1..15).
module dmem_arb_age_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt_reg;
    logic [WAIT_CNT_W-1:0] wait_cnt_next;

    // Clears whenever the debug port is idle or served; saturates rather than wraps.
    always_comb begin
        wait_cnt_next = '0;
        if (dbg_req && !dbg_gnt) begin
            if (wait_cnt_reg == '1)
                wait_cnt_next = wait_cnt_reg;
            else
                wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_next;
    end

    assign force_dbg = dbg_req && (wait_cnt_reg == WAIT_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data RAM between the CPU and a debug port; the CPU
// has strict priority unless built with DMEM_ARB_AGING_EN, which bounds debug waits.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    logic         force_dbg;
    owner_e       winner;
    owner_state_t state_reg;
    owner_state_t state_next;

    logic [DATA_W-1:0] cpu_rdata_reg;
    logic [DATA_W-1:0] dbg_rdata_reg;

`ifdef DMEM_ARB_AGING_EN
    dmem_arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_counter (
        .clock     (clock),
        .reset     (reset),
        .dbg_req   (bus.dbg_req),
        .dbg_gnt   (bus.dbg_gnt),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    // Grants are held low for the whole of reset, not just at the next edge.
    always_comb begin
        winner = OWN_NONE;
        if (reset)
            winner = pick_winner(bus.cpu_req, bus.dbg_req, force_dbg);
    end

    assign bus.cpu_gnt = (winner == OWN_CPU);
    assign bus.dbg_gnt = (winner == OWN_DBG);

    always_comb begin
        bus.ram_wEn    = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_dataIn = '0;
        state_next     = '{owner: winner, rd: 1'b0};
        case (winner)
            OWN_CPU: begin
                bus.ram_wEn    = bus.cpu_we;
                bus.ram_addr   = bus.cpu_addr;
                bus.ram_dataIn = bus.cpu_wdata;
                state_next.rd  = !bus.cpu_we;
            end
            OWN_DBG: begin
                bus.ram_wEn    = bus.dbg_we;
                bus.ram_addr   = bus.dbg_addr;
                bus.ram_dataIn = bus.dbg_wdata;
                state_next.rd  = !bus.dbg_we;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rvalid = (state_reg.owner == OWN_CPU) && state_reg.rd;
    assign bus.dbg_rvalid = (state_reg.owner == OWN_DBG) && state_reg.rd;

    // Read data flows straight from the RAM in the return cycle and is captured
    // so each port keeps showing its last result afterwards.
    assign bus.cpu_rdata = bus.cpu_rvalid ? bus.ram_dataOut : cpu_rdata_reg;
    assign bus.dbg_rdata = bus.dbg_rvalid ? bus.ram_dataOut : dbg_rdata_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= '{owner: OWN_NONE, rd: 1'b0};
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (bus.cpu_rvalid)
                cpu_rdata_reg <= bus.ram_dataOut;
            if (bus.dbg_rvalid)
                dbg_rdata_reg <= bus.ram_dataOut;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter: a reference model predicts each
// grant and read return; a monitor compares read returns as they appear.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    typedef struct packed {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    // Environment RAM: one-cycle registered read, write at the clock edge.
    logic [DATA_W-1:0] ram [2**ADDR_W];
    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
        bus.ram_dataOut = '0;
    end
    always @(posedge clock) begin
        if (bus.ram_wEn) ram[bus.ram_addr] <= bus.ram_dataIn;
        bus.ram_dataOut <= ram[bus.ram_addr];
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [int];
    int                ref_wait = 0;
    exp_t              exp_q [2][$];
    logic [DATA_W-1:0] last_rdata [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cycle %0d: got 0x%0h, required 0x%0h", name, cycle, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return '0;
    endfunction

    function automatic req_t new_req();
        req_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = ($urandom_range(0, 9) == 0) ? {ADDR_W{1'b1}} : ADDR_W'($urandom_range(0, 15));
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic req_t mk(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        req_t r;
        r.req = req; r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // One bus cycle: drive requests, predict the winner from the priority rules,
    // compare grants and RAM bus, queue the expected read return.
    task automatic step(input req_t c, input req_t d, input bit abort_with_reset,
                        output bit c_won, output bit d_won);
        bit                force_d;
        req_t              w;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_din;
        logic              exp_wen;
        int                port;
        bus.cpu_req = c.req; bus.cpu_we = c.we; bus.cpu_addr = c.addr; bus.cpu_wdata = c.wdata;
        bus.dbg_req = d.req; bus.dbg_we = d.we; bus.dbg_addr = d.addr; bus.dbg_wdata = d.wdata;
        @(negedge clock);
        force_d = AGING && d.req && (ref_wait == MAX_WAIT);
        c_won   = c.req && !force_d;
        d_won   = d.req && !c_won;
        w       = c_won ? c : (d_won ? d : '0);
        port    = c_won ? 0 : 1;
        exp_wen = w.req && w.we;
        exp_addr = w.req ? w.addr : '0;
        exp_din  = w.req ? w.wdata : '0;
        check("cpu_gnt", 64'(bus.cpu_gnt), 64'(c_won));
        check("dbg_gnt", 64'(bus.dbg_gnt), 64'(d_won));
        check("ram_wEn", 64'(bus.ram_wEn), 64'(exp_wen));
        check("ram_addr", 64'(bus.ram_addr), 64'(exp_addr));
        check("ram_dataIn", 64'(bus.ram_dataIn), 64'(exp_din));
        if (w.req)
            $display("txn cycle %0d %s %s addr=0x%03h data=0x%08h", cycle, c_won ? "cpu" : "dbg",
                     w.we ? "WR" : "RD", w.addr, w.we ? w.wdata : mem_read(w.addr));
        if (abort_with_reset) begin
            reset    = 1'b0;
            ref_wait = 0;
        end else begin
            if (w.req && w.we) ref_mem[int'(w.addr)] = w.wdata;
            if (w.req && !w.we) exp_q[port].push_back('{due: cycle + 1, data: mem_read(w.addr)});
            ref_wait = (d.req && !d_won) ? ((ref_wait < 15) ? ref_wait + 1 : 15) : 0;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: read returns are checked whenever the DUT presents them.
    initial forever begin
        logic              rv [2];
        logic [DATA_W-1:0] rd [2];
        @(negedge clock);
        rv[0] = bus.cpu_rvalid; rd[0] = bus.cpu_rdata;
        rv[1] = bus.dbg_rvalid; rd[1] = bus.dbg_rdata;
        for (int p = 0; p < 2; p++) begin
            string nm;
            bit    due_now;
            nm = (p == 0) ? "cpu" : "dbg";
            if (!reset) begin
                check({nm, "_rvalid_in_reset"}, 64'(rv[p]), 64'd0);
                check({nm, "_rdata_in_reset"}, 64'(rd[p]), 64'd0);
                last_rdata[p] = '0;
            end else begin
                due_now = (exp_q[p].size() > 0) && (exp_q[p][0].due == cycle);
                check({nm, "_rvalid"}, 64'(rv[p]), 64'(due_now));
                if (due_now) begin
                    exp_t e;
                    e = exp_q[p].pop_front();
                    if (rv[p]) check({nm, "_rdata"}, 64'(rd[p]), 64'(e.data));
                    last_rdata[p] = e.data;
                end else if (!rv[p]) begin
                    check({nm, "_rdata_hold"}, 64'(rd[p]), 64'(last_rdata[p]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   cw, dw;
        req_t idle, c_p, d_p;
        int   dbg_wins;
        idle = '0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;

        // Reset held with both ports requesting.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 32'h1111_1111;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 12'h020; bus.dbg_wdata = 32'h2222_2222;
        repeat (3) begin
            @(negedge clock);
            check("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
            check("rst_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
            check("rst_ram_wEn", 64'(bus.ram_wEn), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;

        // CPU write wins over debug on the first edge, then CPU read-back.
        step(mk(1, 1, 12'h010, 32'hDEADBEEF), mk(1, 0, 12'h020, 0), 0, cw, dw);
        step(mk(1, 0, 12'h010, 0), idle, 0, cw, dw);
        // Debug-only read of the same word.
        step(idle, mk(1, 0, 12'h010, 0), 0, cw, dw);
        step(idle, idle, 0, cw, dw);
        check("model_word_0x010", 64'(mem_read(12'h010)), 64'hDEADBEEF);

        // Sustained contention: back-to-back reads from both ports.
        ref_wait = 0;
        dbg_wins = 0;
        for (int i = 0; i < 20; i++) begin
            step(mk(1, 0, 12'h010, 0), mk(1, 0, 12'(12'h010 + i), 0), 0, cw, dw);
            if (dw) dbg_wins++;
        end
        step(idle, idle, 0, cw, dw);
        $display("contention: dbg granted %0d of 20 cycles (aging=%0d)", dbg_wins, AGING);

        // Random traffic; a pending request holds its fields until granted.
        c_p = idle;
        d_p = idle;
        for (int i = 0; i < 200; i++) begin
            if (!c_p.req && $urandom_range(0, 99) < 60) c_p = new_req();
            if (!d_p.req && $urandom_range(0, 99) < 45) d_p = new_req();
            step(c_p, d_p, 0, cw, dw);
            if (cw) c_p.req = 1'b0;
            if (dw) d_p.req = 1'b0;
        end
        step(idle, idle, 0, cw, dw);
        step(idle, idle, 0, cw, dw);

        // Reset arrives between a debug read grant and its return edge.
        step(idle, mk(1, 0, 12'h010, 0), 1, cw, dw);
        bus.cpu_req = 1'b1;
        bus.dbg_req = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("midrst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
            check("midrst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
            check("midrst_dbg_gnt", 64'(bus.dbg_gnt), 64'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(idle, idle, 0, cw, dw);
        check("post_rst_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        step(idle, idle, 0, cw, dw);
        step(idle, mk(1, 0, 12'h010, 0), 0, cw, dw);
        step(idle, idle, 0, cw, dw);
        step(idle, idle, 0, cw, dw);

        check("cpu_queue_drained", 64'(exp_q[0].size()), 64'd0);
        check("dbg_queue_drained", 64'(exp_q[1].size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
